// File: rtl/lte_cp_strip_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lte_cp_strip_mc_pkg                                                  |
// | FFT size codes, CP base lengths, symbols per slot and FSM states.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lte_cp_strip_mc_pkg;

    localparam int C_FFT_NUM_NBIT = 3;
    localparam int C_CNT_NBIT     = 12;
    localparam int C_SYM_NBIT     = 3;
    localparam int C_CP_LEN_NBIT  = 10;

    localparam logic [C_FFT_NUM_NBIT-1:0] C_FFT_2048 = 3'd0;
    localparam logic [C_FFT_NUM_NBIT-1:0] C_FFT_1536 = 3'd1;
    localparam logic [C_FFT_NUM_NBIT-1:0] C_FFT_1024 = 3'd2;
    localparam logic [C_FFT_NUM_NBIT-1:0] C_FFT_512  = 3'd3;
    localparam logic [C_FFT_NUM_NBIT-1:0] C_FFT_256  = 3'd4;
    localparam logic [C_FFT_NUM_NBIT-1:0] C_FFT_128  = 3'd5;

    localparam logic [C_CP_LEN_NBIT-1:0] C_CP_BASE_NORM_FIRST = 10'd160;
    localparam logic [C_CP_LEN_NBIT-1:0] C_CP_BASE_NORM       = 10'd144;
    localparam logic [C_CP_LEN_NBIT-1:0] C_CP_BASE_EXT        = 10'd512;

    localparam logic [C_SYM_NBIT-1:0] C_LAST_SYM_NORM = 3'd6;
    localparam logic [C_SYM_NBIT-1:0] C_LAST_SYM_EXT  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    function automatic logic fft_legal(input logic [C_FFT_NUM_NBIT-1:0] code);
        return (code <= C_FFT_128);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lte_cp_len_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lte_cp_len_lut                                                       |
// | Maps {FFT size code, CP type, first symbol} to {NFFT, CP length}.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lte_cp_len_lut
    import lte_cp_strip_mc_pkg::*;
(
    input  logic [C_FFT_NUM_NBIT-1:0] i_fft_num,
    input  logic                      i_cp_type,
    input  logic                      i_first_sym,
    output logic [C_CNT_NBIT-1:0]     o_nfft,
    output logic [C_CP_LEN_NBIT-1:0]  o_cp_len
);

    logic [C_CP_LEN_NBIT-1:0] w_base;
    logic [21:0]              w_prod;

    always_comb begin
        o_nfft = 12'd2048;
        case (i_fft_num)
            C_FFT_2048: o_nfft = 12'd2048;
            C_FFT_1536: o_nfft = 12'd1536;
            C_FFT_1024: o_nfft = 12'd1024;
            C_FFT_512:  o_nfft = 12'd512;
            C_FFT_256:  o_nfft = 12'd256;
            C_FFT_128:  o_nfft = 12'd128;
            default:    o_nfft = 12'd2048;
        endcase
    end

    assign w_base = i_cp_type   ? C_CP_BASE_EXT :
                    i_first_sym ? C_CP_BASE_NORM_FIRST : C_CP_BASE_NORM;

    // base*NFFT/2048 is exact for every legal size, so a shift suffices
    assign w_prod   = 22'(w_base) * 22'(o_nfft);
    assign o_cp_len = C_CP_LEN_NBIT'(w_prod >> 11);

endmodule
`default_nettype wire

// File: rtl/lte_cp_strip_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lte_cp_strip_mc                                                      |
// | Multi-channel CP removal and symbol framer for the LTE FFT engine.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lte_cp_strip_mc
    import lte_cp_strip_mc_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_CH    = 2
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [2:0]                  FFT_num,
    input  logic                        CP_type,
    input  logic [NUM_CH*BIT_WIDTH-1:0] Din_i,
    input  logic [NUM_CH*BIT_WIDTH-1:0] Din_q,
    input  logic                        Din_h,
    input  logic                        Din_s,
    input  logic                        Din_v,
    output logic [NUM_CH*BIT_WIDTH-1:0] Dout_i,
    output logic [NUM_CH*BIT_WIDTH-1:0] Dout_q,
    output logic                        Dout_v,
    output logic                        Dout_sop,
    output logic                        Dout_eop,
    output logic [2:0]                  Dout_sym,
    output logic                        Dout_fst_cp,
    output logic                        Dout_err
);

    state_t                   r_state;
    logic [C_CNT_NBIT-1:0]    r_cnt;
    logic [C_SYM_NBIT-1:0]    r_sym;
    logic [C_FFT_NUM_NBIT-1:0] r_fft;
    logic                     r_cp;

    logic [C_CNT_NBIT-1:0]    w_nfft;
    logic [C_CP_LEN_NBIT-1:0] w_cp_len;
    logic [C_SYM_NBIT-1:0]    w_last_sym;
    logic                     w_s, w_h, w_in_body, w_eop, w_fwd, w_err, w_cp_last;

    lte_cp_len_lut u_lut (
        .i_fft_num   (r_fft),
        .i_cp_type   (r_cp),
        .i_first_sym (r_sym == 3'd0),
        .o_nfft      (w_nfft),
        .o_cp_len    (w_cp_len)
    );

    assign w_s        = Din_v & Din_s;
    assign w_h        = Din_v & Din_h;
    assign w_last_sym = r_cp ? C_LAST_SYM_EXT : C_LAST_SYM_NORM;
    assign w_cp_last  = (r_cnt == (C_CNT_NBIT'(w_cp_len) - 12'd1));
    assign w_in_body  = Din_v & (r_state == ST_BODY);
    assign w_eop      = w_in_body & (r_cnt == (w_nfft - 12'd1));
    // A slot start inside BODY is CP sample 0 of the new slot, unless it lands on the eop
    assign w_fwd      = w_in_body & (~w_s | w_eop);
    assign w_err      = (w_h & ~w_s & ~((r_state == ST_CP) && (r_cnt == 12'd0)))
                      | (w_s & ~fft_legal(FFT_num))
                      | (w_s & w_in_body & ~w_eop);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sym       <= '0;
            r_fft       <= '0;
            r_cp        <= 1'b0;
            Dout_v      <= 1'b0;
            Dout_sop    <= 1'b0;
            Dout_eop    <= 1'b0;
            Dout_sym    <= '0;
            Dout_fst_cp <= 1'b0;
            Dout_err    <= 1'b0;
        end else begin
            if (w_s) begin
                r_fft <= FFT_num;
                r_cp  <= CP_type;
                r_sym <= '0;
                if (fft_legal(FFT_num)) begin
                    r_state <= ST_CP;
                    r_cnt   <= 12'd1;
                end else begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            end else if (Din_v) begin
                case (r_state)
                    ST_CP: begin
                        if (w_cp_last) begin
                            r_state <= ST_BODY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 12'd1;
                        end
                    end
                    ST_BODY: begin
                        if (w_eop) begin
                            r_cnt <= '0;
                            if (r_sym == w_last_sym) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_sym   <= r_sym + 3'd1;
                                r_state <= ST_CP;
                            end
                        end else begin
                            r_cnt <= r_cnt + 12'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            Dout_v   <= w_fwd;
            Dout_sop <= w_fwd & (r_cnt == 12'd0);
            Dout_eop <= w_eop;
            Dout_err <= w_err;
            if (w_fwd) begin
                Dout_sym    <= r_sym;
                Dout_fst_cp <= ~r_cp & (r_sym == 3'd0);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BIT_WIDTH-1:0] r_i;
        logic [BIT_WIDTH-1:0] r_q;

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_i <= '0;
                r_q <= '0;
            end else if (w_fwd) begin
                r_i <= Din_i[c*BIT_WIDTH +: BIT_WIDTH];
                r_q <= Din_q[c*BIT_WIDTH +: BIT_WIDTH];
            end
        end

        assign Dout_i[c*BIT_WIDTH +: BIT_WIDTH] = r_i;
        assign Dout_q[c*BIT_WIDTH +: BIT_WIDTH] = r_q;
    end

endmodule
`default_nettype wire
